// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the ASCII UART transmitter slice.
//   UART_DATA_BITS : payload bits per frame (8N1)
//   uart_state_t   : transmitter FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/ascii_uart_tx_if.sv
// -----------------------------------------------------------------------------
// ascii_uart_tx_if
// Valid/ready byte stream from the message sequencer into the transmitter.
//   in_data  : ASCII byte, driven by the master
//   in_valid : in_data valid this cycle, driven by the master
//   in_ready : transmitter FIFO can accept, driven by the slave
// -----------------------------------------------------------------------------
interface ascii_uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with registered occupancy count, no write-through.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : push request (ignored when full)
//   wr_data    : byte to push
//   rd_en      : pop request (ignored when empty)
//   rd_data    : head byte (valid while !empty)
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : number of stored bytes
// -----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [UART_DATA_BITS-1:0]   wr_data,
    input  logic                        rd_en,
    output logic [UART_DATA_BITS-1:0]   rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]            count_q, count_d;
    logic                      do_wr, do_rd;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ascii_uart_tx.sv
// -----------------------------------------------------------------------------
// ascii_uart_tx
// 8N1 LSB-first UART transmitter fed by a valid/ready byte stream through a
// small FIFO so the upstream character generator can burst.
//   clk, reset : clock, asynchronous active-high reset
//   in_if      : slave side of the byte stream (in_data/in_valid/in_ready)
//   tx         : serial line, idles high
//   busy       : frame on the line or bytes queued
//   frame_done : one-cycle pulse on the last cycle of each stop bit
// -----------------------------------------------------------------------------
module ascii_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ascii_uart_tx_if.slave        in_if,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;

    logic                      pop;
    logic                      baud_last;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign in_if.in_ready = !fifo_full;
    assign baud_last      = (baud_q == BAUD_LAST);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_if.in_valid),
        .wr_data (in_if.in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_rd_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    sh_d   = sh_q >> 1;
                    if (bit_q == BIT_LAST) state_d = ST_STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end
            end
            ST_STOP: begin
                // A queued byte is popped on the final stop cycle so the next
                // start bit follows with no idle gap.
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_rd_data;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded from registered state so reset forces the line high at once.
    always_comb begin
        tx         = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = sh_q[0];
            ST_STOP:  frame_done = baud_last;
            default:  tx = 1'b1;
        endcase
    end

    assign busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ascii_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_ascii_uart_tx
// Self-checking bench for ascii_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line-level reference model (byte queue + frame-relative cycle time) gives
// the expected tx/busy/frame_done/in_ready on every cycle; tables and directed
// sequences cover frame shape, bursts, same-edge push/pop, async reset and
// backpressure.
// -----------------------------------------------------------------------------
module tb_ascii_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx, busy, frame_done;

    ascii_uart_tx_if in_if ();

    ascii_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (in_if.slave),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_seen  = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_cur    = '0;
    int         m_t      = 0;
    bit         m_active = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            bit push;
            push = in_if.in_valid && (m_q.size() < DEPTH);
            if (m_active) begin
                if (m_t == FRAME - 1) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                        m_t   = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_t++;
                end
            end else if (m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_t      = 0;
                m_active = 1'b1;
            end
            if (push) m_q.push_back(in_if.in_data);
        end
    end

    function automatic logic exp_tx();
        if (!m_active)      return 1'b1;
        if (m_t < CPB)      return 1'b0;
        if (m_t < 9 * CPB)  return m_cur[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            check("tx",         32'(tx),             32'(exp_tx()));
            check("busy",       32'(busy),           32'(m_active || (m_q.size() != 0)));
            check("frame_done", 32'(frame_done),     32'(m_active && (m_t == FRAME - 1)));
            check("in_ready",   32'(in_if.in_ready), 32'(m_q.size() < DEPTH));
            if (frame_done) fd_seen++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || (m_q.size() != 0)) && n < budget) begin
            tick();
            n++;
        end
        check("idle_wait_timeout", 32'(n < budget), 32'(1));
        tick();
    endtask

    task automatic send_stream(input logic [7:0] b[$], input bit garbage, output bit saw_block);
        int  i;
        int  guard;
        bit  rdy;
        i = 0;
        guard = 0;
        saw_block = 1'b0;
        while (i < b.size() && guard < 2000) begin
            rdy = in_if.in_ready;
            if (rdy) begin
                in_if.in_data = b[i];
            end else begin
                saw_block = 1'b1;
                in_if.in_data = garbage ? 8'($urandom) : b[i];
            end
            in_if.in_valid = 1'b1;
            tick();
            if (rdy) i++;
            guard++;
        end
        in_if.in_valid = 1'b0;
        check("stream_timeout", 32'(guard < 2000), 32'(1));
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit slot, slot 0 = start bit
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] bytes[$];
        bit         blk;
        int         fd0;
        int         fd_at;
        int         n;

        vecs[0] = '{data: 8'h47, frame: 10'b1_01000111_0};
        vecs[1] = '{data: 8'h75, frame: 10'b1_01110101_0};
        vecs[2] = '{data: 8'h00, frame: 10'b1_00000000_0};
        vecs[3] = '{data: 8'hFF, frame: 10'b1_11111111_0};
        vecs[4] = '{data: 8'h55, frame: 10'b1_01010101_0};

        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx",         32'(tx),             32'(1));
        check("rst_in_ready",   32'(in_if.in_ready), 32'(1));
        check("rst_busy",       32'(busy),           32'(0));
        check("rst_frame_done", 32'(frame_done),     32'(0));
        reset = 1'b0;
        repeat (50) tick();

        // Single-frame shape table
        foreach (vecs[k]) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = vecs[k].data;
            tick();
            in_if.in_valid = 1'b0;
            check("no_bypass_tx", 32'(tx), 32'(1));
            fd0   = fd_seen;
            fd_at = -1;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (c % CPB == CPB / 2) check("frame_bit", 32'(tx), 32'(vecs[k].frame[c / CPB]));
                if (frame_done && fd_at < 0) fd_at = c;
            end
            check("frame_done_count", 32'(fd_seen - fd0), 32'(1));
            check("frame_length",     32'(fd_at),         32'(FRAME - 1));
            tick();
            check("post_frame_tx",   32'(tx),   32'(1));
            check("post_frame_busy", 32'(busy), 32'(0));
        end

        // "Guate" burst with in_valid held
        bytes = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65};
        fd0 = fd_seen;
        send_stream(bytes, 1'b0, blk);
        check("burst_ready_drop", 32'(in_if.in_ready), 32'(0));
        check("burst_busy",       32'(busy),           32'(1));
        wait_idle(FRAME * 8);
        check("burst_frames", 32'(fd_seen - fd0), 32'(5));

        // Push on the same edge as a pop with two bytes queued
        bytes = '{8'h31, 8'h32, 8'h33};
        fd0 = fd_seen;
        send_stream(bytes, 1'b0, blk);
        n = 0;
        while (!(m_active && m_t == FRAME - 1) && n < 200) begin tick(); n++; end
        check("same_edge_wait", 32'(n < 200), 32'(1));
        check("same_edge_pre_count", 32'(dut.u_fifo.count), 32'(2));
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'h51;
        tick();
        in_if.in_valid = 1'b0;
        check("same_edge_count", 32'(dut.u_fifo.count), 32'(2));
        wait_idle(FRAME * 6);
        check("same_edge_frames", 32'(fd_seen - fd0), 32'(4));

        // Asynchronous reset during data bit 3 of 0x61 with two bytes queued
        bytes = '{8'h61, 8'h62, 8'h63};
        send_stream(bytes, 1'b0, blk);
        n = 0;
        while (!(m_active && m_cur == 8'h61 && m_t == 4 * CPB + 1) && n < 200) begin tick(); n++; end
        check("rst_mid_wait", 32'(n < 200), 32'(1));
        check("rst_mid_bit3", 32'(tx), 32'(0));
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx",    32'(tx),                32'(1));
        check("async_rst_busy",  32'(busy),              32'(0));
        check("async_rst_ready", 32'(in_if.in_ready),    32'(1));
        check("async_rst_count", 32'(dut.u_fifo.count),  32'(0));
        tick();
        reset = 1'b0;
        fd0 = fd_seen;
        repeat (60) tick();
        check("post_rst_frames", 32'(fd_seen - fd0), 32'(0));
        check("post_rst_busy",   32'(busy),          32'(0));

        // Backpressure with in_data changing while blocked
        bytes = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0D, 8'h0A};
        fd0 = fd_seen;
        send_stream(bytes, 1'b1, blk);
        check("backpressure_seen", 32'(blk), 32'(1));
        wait_idle(FRAME * 8);
        check("backpressure_frames", 32'(fd_seen - fd0), 32'(8));

        // Randomized traffic at two load levels
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1200; c++) begin
                in_if.in_valid = ($urandom_range(0, 99) < (phase == 0 ? 8 : 60));
                in_if.in_data  = 8'($urandom);
                tick();
            end
            in_if.in_valid = 1'b0;
            wait_idle(FRAME * (DEPTH + 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_uart_tx.md
# ascii_uart_tx

Serializes the 8-bit ASCII character stream from the message-sequencer stage onto a single UART line (8N1, LSB first). Incoming bytes pass through a valid/ready handshake into a small FIFO, so the producer can burst several characters while the transmitter works through them at the bit rate. Sits directly downstream of the character generator and drives the chip's serial output pin.

## Interface
- CLKS_PER_BIT, 16: clk cycles per UART bit; must be ≥ 2.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of two, ≥ 2.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_data  input  8  ASCII byte from upstream.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept; equals !full (combinational from registered count).
- tx  output  1  UART line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- Push: on a posedge with in_valid && in_ready, in_data is written at the FIFO tail. When in_ready=0, in_valid is ignored; the byte is not lost, upstream holds it.
- FSM states:
  - IDLE: tx=1. If FIFO is non-empty, pop the head into shift register sh[7:0] and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift right, index+1. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, frame_done=1.
    - FIFO non-empty: pop and go straight to START, with no idle gap.
    - FIFO empty: go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Reloads to 0 on every state or bit change. Counts 0..CLKS_PER_BIT-1.
- FIFO: pointer width $clog2(FIFO_DEPTH). Count width $clog2(FIFO_DEPTH)+1. Pointers wrap naturally.
  - full = (count==FIFO_DEPTH).
  - Push and pop on the same edge leave count unchanged.
  - No write-through bypass: a byte pushed into an empty FIFO is popped at the earliest on the next edge.
- Reset values: tx=1, in_ready=1, busy=0, frame_done=0. FSM=IDLE, FIFO empty, counters 0, sh=0.
- Reset mid-frame: frame is abandoned and tx returns to 1 asynchronously. All queued bytes are discarded.

## Timing
- Byte accepted at edge N into an empty FIFO with FSM in IDLE:
  - Pop at edge N+1; tx falls after edge N+1.
  - Start bit covers cycles N+1 .. N+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles (start, 8 data bits, stop).
- Back-to-back frames: the next start bit begins on the cycle after the frame_done cycle.
- in_ready deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop that frees an entry.
- busy rises the cycle after the first accepted push. It falls the cycle after the frame_done of the final frame, when the FIFO is empty.

## Structure
- Shared package uart_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3.
  - UART_DATA_BITS=8.
- One sub-module: byte_fifo (parameter DEPTH), with ports clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty, count.
- ascii_uart_tx holds the FSM, baud counter, bit index and shift register.

## Test plan
- Reset, then idle for 50 cycles → tx=1, in_ready=1, busy=0, frame_done=0 throughout.
- CLKS_PER_BIT=4, push 0x47 ('G') → after the 4-cycle start bit, tx shows 1,1,1,0,0,0,1,0 (each held 4 cycles). Stop bit is 4 cycles, frame_done pulses once, total frame is 40 cycles.
- Hold in_valid continuously with bytes 0x47,0x75,0x61,0x74,0x65 ("Guate"), FIFO_DEPTH=4:
  - in_ready drops when the FIFO fills.
  - All 5 bytes are transmitted in order with no idle gap.
  - busy stays high from the first push until after the fifth frame_done.
- Push 0x51 at the same edge the FIFO pops (count=2) → count stays 2 and the byte order is preserved.
- Assert reset during data bit 3 of 0x61 with 2 bytes queued → tx=1 immediately (asynchronous). After release: FIFO empty, busy=0, no further frames.
- in_valid held while in_ready=0 with in_data changing → no byte is accepted until in_ready=1. The transmitted stream contains only the bytes sampled under the handshake.
